// File: rtl/vga_pkg.sv
// Shared VGA drawing constants and the draw scheduler state encoding.
package vga_pkg;

  localparam int X_W = 8;
  localparam int Y_W = 7;
  localparam int C_W = 8;

  localparam int SCREEN_W = 160;
  localparam int SCREEN_H = 120;

  localparam logic [C_W-1:0] KEY_COLOUR_DEFAULT = 8'h09;
  // One full-screen drawer pass plus margin.
  localparam int TIMEOUT_DEFAULT = SCREEN_W * SCREEN_H + 800;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SELECT = 3'd1,
    START  = 3'd2,
    WAIT   = 3'd3,
    DONE   = 3'd4
  } schedState_t;

  function automatic logic [7:0] satInc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/lowest_bit_select.sv
// Combinational priority picker: index of the lowest set bit plus a valid flag.
module lowest_bit_select #(
  parameter int N = 4,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  // Scan downwards so the lowest set bit is the last one to land in idx.
  always_comb begin
    idx   = '0;
    valid = |vec;
    for (int i = N - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
  end

endmodule

// File: rtl/draw_scheduler.sv
// Time-shares the VGA pixel-write port among layered drawers, background first,
// with transparency keying, a per-layer watchdog and frame-overrun accounting.
module draw_scheduler
  import vga_pkg::*;
#(
  parameter int              N_LAYERS   = 4,
  parameter logic [C_W-1:0]  KEY_COLOUR = KEY_COLOUR_DEFAULT,
  parameter int              TIMEOUT    = TIMEOUT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    frameTick,
  input  logic [N_LAYERS-1:0]     layerEn,
  output logic [N_LAYERS-1:0]     startLayer,
  input  logic [X_W*N_LAYERS-1:0] layerX,
  input  logic [Y_W*N_LAYERS-1:0] layerY,
  input  logic [C_W*N_LAYERS-1:0] layerC,
  input  logic [N_LAYERS-1:0]     layerW,
  input  logic [N_LAYERS-1:0]     layerDone,
  output logic [X_W-1:0]          x,
  output logic [Y_W-1:0]          y,
  output logic [C_W-1:0]          colour,
  output logic                    writeEn,
  output logic                    busy,
  output logic                    frameDone,
  output logic                    timeoutErr,
  output logic [7:0]              overrunCount
);

  localparam int IDX_W = (N_LAYERS > 1) ? $clog2(N_LAYERS) : 1;
  localparam int WD_W  = $clog2(TIMEOUT + 1);

  schedState_t         state, nextState;
  logic [N_LAYERS-1:0] pending, pendingNext;
  logic [IDX_W-1:0]    cur, curNext;
  logic [WD_W-1:0]     watchdog, watchdogNext;
  logic [N_LAYERS-1:0] startNext;
  logic [X_W-1:0]      xNext;
  logic [Y_W-1:0]      yNext;
  logic [C_W-1:0]      colourNext;
  logic                writeEnNext, busyNext, frameDoneNext, timeoutErrNext;
  logic [7:0]          overrunNext;

  logic [IDX_W-1:0]    lowIdx;
  logic                lowValid;
  logic [X_W-1:0]      curX;
  logic [Y_W-1:0]      curY;
  logic [C_W-1:0]      curC;
  logic                curW, curDone, pixelOk;

  lowest_bit_select #(.N(N_LAYERS)) uSelect (
    .vec   (pending),
    .idx   (lowIdx),
    .valid (lowValid)
  );

  assign curX    = layerX[int'(cur) * X_W +: X_W];
  assign curY    = layerY[int'(cur) * Y_W +: Y_W];
  assign curC    = layerC[int'(cur) * C_W +: C_W];
  assign curW    = layerW[cur];
  assign curDone = layerDone[cur];
  assign pixelOk = curW && (curC != KEY_COLOUR);

  // Next-state and next-output decode for the frame sequencer.
  always_comb begin
    nextState      = state;
    pendingNext    = pending;
    curNext        = cur;
    watchdogNext   = watchdog;
    startNext      = '0;
    xNext          = x;
    yNext          = y;
    colourNext     = colour;
    writeEnNext    = 1'b0;
    busyNext       = busy;
    frameDoneNext  = 1'b0;
    timeoutErrNext = timeoutErr;

    if (frameTick && (state != IDLE)) begin
      overrunNext = satInc8(overrunCount);
    end else begin
      overrunNext = overrunCount;
    end

    case (state)
      IDLE: begin
        if (frameTick) begin
          pendingNext = layerEn;
          busyNext    = 1'b1;
          nextState   = SELECT;
        end else begin
          nextState = IDLE;
        end
      end
      SELECT: begin
        if (!lowValid) begin
          frameDoneNext = 1'b1;
          nextState     = DONE;
        end else begin
          curNext           = lowIdx;
          startNext[lowIdx] = 1'b1;
          nextState         = START;
        end
      end
      START: begin
        pendingNext[cur] = 1'b0;
        watchdogNext     = WD_W'(TIMEOUT);
        nextState        = WAIT;
      end
      WAIT: begin
        xNext        = curX;
        yNext        = curY;
        colourNext   = curC;
        watchdogNext = watchdog - WD_W'(1);
        // Done beats a simultaneous watchdog expiry.
        if (curDone) begin
          writeEnNext = pixelOk;
          nextState   = SELECT;
        end else if (watchdog == WD_W'(1)) begin
          timeoutErrNext = 1'b1;
          writeEnNext    = 1'b0;
          nextState      = SELECT;
        end else begin
          writeEnNext = pixelOk;
          nextState   = WAIT;
        end
      end
      DONE: begin
        busyNext  = 1'b0;
        nextState = IDLE;
      end
      default: begin
        busyNext  = 1'b0;
        nextState = IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any frame in flight.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state        <= IDLE;
      pending      <= '0;
      cur          <= '0;
      watchdog     <= '0;
      startLayer   <= '0;
      x            <= '0;
      y            <= '0;
      colour       <= '0;
      writeEn      <= 1'b0;
      busy         <= 1'b0;
      frameDone    <= 1'b0;
      timeoutErr   <= 1'b0;
      overrunCount <= 8'd0;
    end else begin
      state        <= nextState;
      pending      <= pendingNext;
      cur          <= curNext;
      watchdog     <= watchdogNext;
      startLayer   <= startNext;
      x            <= xNext;
      y            <= yNext;
      colour       <= colourNext;
      writeEn      <= writeEnNext;
      busy         <= busyNext;
      frameDone    <= frameDoneNext;
      timeoutErr   <= timeoutErrNext;
      overrunCount <= overrunNext;
    end
  end

endmodule

// File: doc/draw_scheduler.md
Name: draw_scheduler

Overview:
- Shares the single VGA pixel-write port (x, y, colour, writeEn) among up to N_LAYERS sprite/background drawer instances.
- On each frame tick, starts the enabled layers one at a time in fixed priority order (layer 0 = background, drawn first) and muxes the active drawer's pixel stream to the adapter.
- Applies the transparency key, guards against hung drawers with a watchdog, and reports frame completion to the top-level game FSM.

Parameters:
N_LAYERS, 4, number of drawer clients; layer index 0 has highest priority and is drawn first
KEY_COLOUR, 8'h09, "green screen" colour; pixels of this colour are suppressed
TIMEOUT, 20000, max cycles a layer may run before being abandoned (160*120 plus margin)

Ports:
clk  in  1  system clock
resetn  in  1  synchronous active-low reset
frameTick  in  1  one-cycle frame request pulse (rate divider OR manual start)
layerEn  in  N_LAYERS  layers to draw this frame; sampled only when a frame is accepted
startLayer  out  N_LAYERS  one-hot, one-cycle start pulse to a drawer
layerX  in  8*N_LAYERS  packed drawer x outputs, layer i at [8i+7:8i]
layerY  in  7*N_LAYERS  packed drawer y outputs
layerC  in  8*N_LAYERS  packed drawer colours
layerW  in  N_LAYERS  drawer write enables
layerDone  in  N_LAYERS  drawer done pulses
x  out  8  registered pixel x
y  out  7  registered pixel y
colour  out  8  registered pixel colour
writeEn  out  1  registered pixel write strobe
busy  out  1  high from frame accept until return to IDLE
frameDone  out  1  one-cycle pulse when a frame finishes
timeoutErr  out  1  sticky; set on any watchdog expiry, cleared only by reset
overrunCount  out  8  saturating count of frameTicks ignored while busy

Behaviour:
- Reset (synchronous, resetn=0): state=IDLE; pending=0; x=0, y=0, colour=0; writeEn=0, startLayer=0, busy=0, frameDone=0, timeoutErr=0, overrunCount=0; watchdog=0. Reset mid-frame abandons the frame immediately and issues no frameDone.
- States: IDLE, SELECT, START, WAIT, DONE.
- IDLE: on frameTick, pending<=layerEn, busy<=1, go to SELECT.
- SELECT: if pending==0, go to DONE (this covers an empty layerEn: frameDone arrives 2 cycles after frameTick). Otherwise cur<=lowest set bit of pending and go to START.
- START: startLayer[cur]=1 for exactly this cycle; clear pending[cur]; watchdog<=TIMEOUT; go to WAIT.
- WAIT: each cycle register x/y/colour from slice cur. writeEn<=layerW[cur] & (layerC slice cur != KEY_COLOUR). Latency is 1 cycle from drawer outputs to port outputs. Watchdog decrements each cycle.
  - layerDone[cur]=1: go to SELECT; the pixel presented in that same cycle is still forwarded.
  - Watchdog reaches 0 without done: set timeoutErr, writeEn<=0, go to SELECT.
  - layerDone from a non-current layer is ignored.
  - If done and watchdog expiry occur in the same cycle, done wins and timeoutErr is not set.
- Outside WAIT, writeEn=0; x/y/colour hold their last value.
- DONE: frameDone=1 for one cycle; busy<=0; go to IDLE.
- frameTick while not in IDLE is ignored and overrunCount increments, saturating at 255. frameTick in the DONE cycle counts as an overrun.
- Changes to layerEn during a frame have no effect until the next accepted frame.
- Frame order is strictly ascending layer index, so foreground layers overwrite the background.

Decomposition:
- Shared package (vga_pkg):
  - state encodings
  - X_W=8, Y_W=7, C_W=8
  - KEY_COLOUR default
  - screen constants 160x120
- One sub-module: lowest_bit_select. Combinational: N-bit vector in, index plus valid out. It is instantiated once for SELECT.

Test Plan:
- layerEn=4'b0101, stub drawers each emit 3 pixels then done -> startLayer pulses 0001 then 0100; 6 writes in order L0 then L2; frameDone once; busy low afterwards.
- Layer 0 emits colour 8'h09 with layerW=1 and colour 8'h1F with layerW=1 -> only the 8'h1F pixel produces writeEn=1, one cycle after input.
- layerEn=0, frameTick -> no startLayer; frameDone pulses 2 cycles after frameTick.
- Layer 1 never asserts done, TIMEOUT=16 -> abandoned after 16 WAIT cycles; timeoutErr=1; layer 2 still starts; frameDone still pulses.
- 300 frameTicks during a long frame -> overrunCount saturates at 255; frame completes normally.
- resetn=0 asserted in WAIT of layer 1 -> next cycle all outputs 0 and state IDLE; no frameDone; a fresh frameTick restarts from layer 0.
